iodelay_tap_sequencer: RTL
==========================

# iodelay_tap_sequencer

Sequences tap loading for a bank of IDELAYE2 elements (RGMII RX data/ctl lanes) in VAR_LOAD mode, gated by the IDELAYCTRL RDY output. After IDELAYCTRL reports ready, it loads every lane with its stored tap and verifies each lane by read-back. It then serves runtime per-lane tap updates from a valid/ready config port, retrying failed loads. It sits between the control/CSR logic and the RX IDELAYE2 instances, in the IDELAYE2 C clock domain.

## Interface
Parameters:
- lanes_p, 5, number of IDELAYE2 lanes (rxd[3:0] + rx_ctl)
- tap_width_p, 5, CNTVALUE width (fixed by IDELAYE2)
- init_tap_p, 0, reset tap value for every lane
- settle_cycles_p, 4, wait cycles between LD pulse and read-back (≥1)
- max_retry_p, 3, extra load attempts after a read-back mismatch

Ports:
- clk_i  in  1  IDELAYE2 C clock
- reset_n_i  in  1  asynchronous, active-low reset
- idelayctrl_rdy_i  in  1  IDELAYCTRL RDY; asynchronous, synchronized internally
- cfg_v_i  in  1  tap update request valid
- cfg_lane_i  in  $clog2(lanes_p)  target lane
- cfg_tap_i  in  tap_width_p  requested tap
- cfg_ready_o  out  1  update accepted when high with cfg_v_i
- ld_o  out  lanes_p  per-lane IDELAYE2 LD, one-hot pulse
- cntvaluein_o  out  tap_width_p  shared CNTVALUEIN bus
- cntvalueout_i  in  lanes_p*tap_width_p  per-lane CNTVALUEOUT, lane i at [i*tap_width_p +: tap_width_p]
- tap_r_o  out  lanes_p*tap_width_p  last verified tap per lane
- done_o  out  1  initial load complete, block operational
- error_o  out  1  sticky: retries exhausted or out-of-range lane

## Operation
- Reset values: state WAIT_RDY, ld_o=0, cntvaluein_o=0, cfg_ready_o=0, done_o=0, error_o=0, every tap_r_o lane = init_tap_p, counters 0.
- rdy_sync = idelayctrl_rdy_i through 2 flops, both reset to 0.
- WAIT_RDY: on rdy_sync=1, lane_r<=0, target<=tap_r_o[0], go to LOAD (init pass).
- LOAD (1 cycle): ld_o[lane_r]=1, cntvaluein_o=target. Go to SETTLE, settle_cnt<=0.
- SETTLE: count settle_cycles_p cycles, then go to CHECK.
- CHECK: match (cntvalueout_i lane slice == target) -> tap_r_o[lane_r]<=target, retry_cnt<=0. Mismatch with retry_cnt<max_retry_p -> retry_cnt++, LOAD. Mismatch with retries exhausted -> error_o<=1, tap_r_o unchanged, retry_cnt<=0, advance.
- Advance: during init with lane_r<lanes_p-1 -> lane_r++, target<=tap_r_o[next], LOAD. Otherwise done_o<=1, IDLE.
- IDLE: cfg_ready_o=1 (only state where it is high). Handshake with cfg_lane_i<lanes_p -> lane_r<=cfg_lane_i, target<=cfg_tap_i, LOAD (runtime pass). Lane out of range -> accepted, dropped, error_o<=1, stays IDLE.
- Loss of RDY: rdy_sync=0 in any state other than WAIT_RDY -> WAIT_RDY next cycle. done_o<=0, ld_o low, retry_cnt cleared, in-flight request abandoned (tap_r_o not updated). On RDY return, the init pass reloads current tap_r_o values, restoring the last verified taps.
- cntvaluein_o is registered and holds the last target between loads.
- error_o is cleared only by reset.

## Timing
- RDY rise to first ld_o: 2 sync cycles + 1 (WAIT_RDY->LOAD) = LD in the 4th cycle after the raw rise edge.
- Runtime update, handshake at edge T: ld_o high during cycle T+1 only. SETTLE T+2..T+1+settle_cycles_p. CHECK at T+2+settle_cycles_p. tap_r_o updated and cfg_ready_o high at T+3+settle_cycles_p (7 cycles with defaults, no retry).
- Each retry adds 2+settle_cycles_p cycles.
- Init pass, no retries: lanes_p*(2+settle_cycles_p) cycles, then done_o rises with IDLE entry.
- At most one ld_o bit high in any cycle. ld_o is never high outside LOAD.

## Structure
- Package iodelay_ctrl_pkg: state enum (WAIT_RDY, LOAD, SETTLE, CHECK, IDLE), IDELAYE2 tap width constant (5), max tap 31.
- Sub-module: bsg_sync_sync (width 1) for the RDY synchronizer. Everything else is inline: FSM, lane/settle/retry counters, tap_r_o register file.

## Test plan
- Reset, RDY rises, model echoes loads: 5 one-hot LD pulses lanes 0..4 with cntvaluein_o=0, 6 cycles apart; done_o=1 after the last check; error_o=0.
- Write lane 2 tap 17 in IDLE: ld_o=5'b00100 at T+1 with cntvaluein_o=17; cfg_ready_o=0 until T+7; tap_r_o lane 2 = 17.
- Model ignores first 2 LDs on lane 3 (tap 9): 3 LD pulses; tap_r_o lane 3 = 9; error_o=0. Model never loads: 4 pulses, error_o=1, lane 3 keeps old tap, returns to IDLE.
- Request with cfg_lane_i=6: accepted in 1 cycle, no ld_o, error_o=1.
- Drop RDY during SETTLE of a lane 1 tap 20 write, then restore: done_o=0, no tap update; reload pass reapplies previous taps, including lane 2 = 17; done_o=1.
- Assert reset_n_i low mid-LOAD: ld_o, cfg_ready_o and done_o go to 0 immediately; tap_r_o all = init_tap_p.

Source files
------------

// File: rtl/iodelay_ctrl_pkg.sv
// Purpose: shared IDELAYE2 constants and tap-sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iodelay_ctrl_pkg;

  // CNTVALUEIN/CNTVALUEOUT width of an IDELAYE2 and its largest tap.
  localparam int idelay_tap_width_lp = 5;
  localparam int idelay_max_tap_lp   = 31;

  typedef enum logic [2:0] {
    WAIT_RDY,
    LOAD,
    SETTLE,
    CHECK,
    IDLE
  } seq_state_e;

endpackage

// File: rtl/bsg_sync_sync.sv
// Purpose: two-flop synchronizer for slow level signals crossing into clk_i.
// Latency: 2 clk_i cycles.
// Backpressure: none; the output simply follows the input.
// Ports: clk_i/reset_n_i destination clock and async active-low reset,
//        data_i asynchronous input, data_o synchronized copy (reset to 0).
module bsg_sync_sync #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] meta_r;
  logic [width_p-1:0] sync_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= data_i;
      sync_r <= meta_r;
    end
  end

  assign data_o = sync_r;

endmodule

// File: rtl/iodelay_tap_sequencer.sv
// Purpose: loads and read-back-verifies IDELAYE2 taps (VAR_LOAD) once IDELAYCTRL is ready, then serves runtime tap updates.
// Latency: update handshake to ld_o 1 cycle; to tap_r_o/cfg_ready_o 2+settle_cycles_p cycles per load attempt.
// Backpressure: cfg_ready_o is high only while idle with RDY present; one update is in flight at a time.
// Ports: clk_i/reset_n_i IDELAYE2 C clock and async active-low reset; idelayctrl_rdy_i raw RDY;
//        cfg_v_i/cfg_lane_i/cfg_tap_i/cfg_ready_o update port; ld_o/cntvaluein_o/cntvalueout_i IDELAYE2 side;
//        tap_r_o verified taps; done_o operational; error_o sticky failure flag.
module iodelay_tap_sequencer
  import iodelay_ctrl_pkg::*;
#(
  parameter int lanes_p         = 5,
  parameter int tap_width_p     = idelay_tap_width_lp,
  parameter int init_tap_p      = 0,
  parameter int settle_cycles_p = 4,
  parameter int max_retry_p     = 3
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           idelayctrl_rdy_i,
  input  logic                           cfg_v_i,
  input  logic [$clog2(lanes_p)-1:0]     cfg_lane_i,
  input  logic [tap_width_p-1:0]         cfg_tap_i,
  output logic                           cfg_ready_o,
  output logic [lanes_p-1:0]             ld_o,
  output logic [tap_width_p-1:0]         cntvaluein_o,
  input  logic [lanes_p*tap_width_p-1:0] cntvalueout_i,
  output logic [lanes_p*tap_width_p-1:0] tap_r_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam int lane_w_lp   = $clog2(lanes_p);
  localparam int settle_w_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam int retry_w_lp  = (max_retry_p > 0) ? $clog2(max_retry_p + 1) : 1;

  localparam logic [lane_w_lp-1:0]   last_lane_lp  = lane_w_lp'(lanes_p - 1);
  localparam logic [lane_w_lp:0]     lane_cnt_lp   = (lane_w_lp + 1)'(lanes_p);
  localparam logic [settle_w_lp-1:0] settle_end_lp = settle_w_lp'(settle_cycles_p - 1);
  localparam logic [retry_w_lp-1:0]  retry_max_lp  = retry_w_lp'(max_retry_p);
  localparam logic [tap_width_p-1:0] init_tap_lp   = tap_width_p'(init_tap_p);

  logic rdy_sync;

  seq_state_e                             state_r, state_n;
  logic [lane_w_lp-1:0]                   lane_r, lane_n;
  logic [tap_width_p-1:0]                 target_r, target_n;
  logic [settle_w_lp-1:0]                 settle_r, settle_n;
  logic [retry_w_lp-1:0]                  retry_r, retry_n;
  logic                                   init_r, init_n;
  logic                                   done_r, done_n;
  logic                                   error_r, error_n;
  logic [tap_width_p-1:0]                 cntval_r;
  logic [lanes_p-1:0][tap_width_p-1:0]    tap_r;
  logic [lanes_p-1:0][tap_width_p-1:0]    cntout_w;
  logic                                   tap_we;
  logic                                   advance;

  bsg_sync_sync #(.width_p(1)) rdy_sync_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (idelayctrl_rdy_i),
    .data_o   (rdy_sync)
  );

  assign cntout_w = cntvalueout_i;

  always_comb begin
    state_n     = state_r;
    lane_n      = lane_r;
    target_n    = target_r;
    settle_n    = settle_r;
    retry_n     = retry_r;
    init_n      = init_r;
    done_n      = done_r;
    error_n     = error_r;
    tap_we      = 1'b0;
    advance     = 1'b0;
    ld_o        = '0;
    cfg_ready_o = 1'b0;

    // Losing RDY outranks everything: no LD or handshake is offered in that
    // cycle, and the pending load is abandoned without touching tap_r.
    if ((state_r != WAIT_RDY) && !rdy_sync) begin
      state_n = WAIT_RDY;
      done_n  = 1'b0;
      retry_n = '0;
    end else begin
      case (state_r)
        WAIT_RDY: begin
          if (rdy_sync) begin
            // Init pass replays the stored taps, so a RDY drop restores the
            // last verified settings.
            lane_n   = '0;
            target_n = tap_r[0];
            init_n   = 1'b1;
            state_n  = LOAD;
          end
        end
        LOAD: begin
          ld_o[lane_r] = 1'b1;
          settle_n     = '0;
          state_n      = SETTLE;
        end
        SETTLE: begin
          if (settle_r == settle_end_lp) state_n = CHECK;
          else                           settle_n = settle_r + 1'b1;
        end
        CHECK: begin
          if (cntout_w[lane_r] == target_r) begin
            tap_we  = 1'b1;
            retry_n = '0;
            advance = 1'b1;
          end else if (retry_r < retry_max_lp) begin
            retry_n = retry_r + 1'b1;
            state_n = LOAD;
          end else begin
            error_n = 1'b1;
            retry_n = '0;
            advance = 1'b1;
          end
          if (advance) begin
            if (init_r && (lane_r != last_lane_lp)) begin
              lane_n   = lane_r + 1'b1;
              target_n = tap_r[lane_n];
              state_n  = LOAD;
            end else begin
              init_n  = 1'b0;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        IDLE: begin
          cfg_ready_o = 1'b1;
          if (cfg_v_i) begin
            if ({1'b0, cfg_lane_i} < lane_cnt_lp) begin
              lane_n   = cfg_lane_i;
              target_n = cfg_tap_i;
              state_n  = LOAD;
            end else begin
              // Bad lane: consume the request so the port cannot wedge.
              error_n = 1'b1;
            end
          end
        end
        default: state_n = WAIT_RDY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= WAIT_RDY;
      lane_r   <= '0;
      target_r <= '0;
      settle_r <= '0;
      retry_r  <= '0;
      init_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      cntval_r <= '0;
      tap_r    <= {lanes_p{init_tap_lp}};
    end else begin
      state_r  <= state_n;
      lane_r   <= lane_n;
      target_r <= target_n;
      settle_r <= settle_n;
      retry_r  <= retry_n;
      init_r   <= init_n;
      done_r   <= done_n;
      error_r  <= error_n;
      // CNTVALUEIN is set up on LOAD entry so it is stable while LD is high.
      if (state_n == LOAD) cntval_r <= target_n;
      if (tap_we)          tap_r[lane_r] <= target_r;
    end
  end

  assign cntvaluein_o = cntval_r;
  assign tap_r_o      = tap_r;
  assign done_o       = done_r;
  assign error_o      = error_r;

endmodule
